// File: rtl/pipe_elastic_reg_pkg.sv
// rtl/pipe_elastic_reg_pkg.sv - shared stage states and counter helper for pipe_elastic_reg
package pipe_elastic_reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - one elastic stage: main + skid register, registered ready
module pipe_skid_stage
    import pipe_elastic_reg_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             bubble,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready
);

    stage_state_e     r_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             r_ready;
    logic             w_acc;
    logic             w_drn;

    assign w_acc   = i_valid & r_ready;
    assign w_drn   = (r_state != ST_EMPTY) & i_ready;
    assign o_ready = r_ready;
    assign o_valid = (r_state != ST_EMPTY);
    assign o_data  = r_main;

    // r_ready always tracks (r_state != ST_FULL) but comes straight from a flop
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            r_state <= ST_EMPTY;
            r_main  <= DEFAULT_VAL;
            r_skid  <= DEFAULT_VAL;
            r_ready <= 1'b1;
        end else if (!stall) begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        r_state <= ST_HALF;
                        r_main  <= i_data;
                    end
                end
                ST_HALF: begin
                    if (w_acc && !w_drn) begin
                        r_state <= ST_FULL;
                        r_skid  <= i_data;
                        r_ready <= 1'b0;
                    end else if (!w_acc && w_drn) begin
                        r_state <= ST_EMPTY;
                        r_main  <= DEFAULT_VAL;
                    end else if (w_acc && w_drn) begin
                        r_main  <= i_data;
                    end
                end
                ST_FULL: begin
                    if (w_drn) begin
                        r_state <= ST_HALF;
                        r_main  <= r_skid;
                        r_skid  <= DEFAULT_VAL;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                    r_main  <= DEFAULT_VAL;
                    r_skid  <= DEFAULT_VAL;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_elastic_reg.sv
// rtl/pipe_elastic_reg.sv - DEPTH-stage elastic pipeline register with stall/bubble; PIPE_PERF_CNT_EN adds perf counters
module pipe_elastic_reg
    import pipe_elastic_reg_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               DEPTH       = 1,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             bubble,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_count
`endif
);

    logic             w_valid [DEPTH+1];
    logic             w_ready [DEPTH+1];
    logic [WIDTH-1:0] w_data  [DEPTH+1];
    logic             w_block;

    assign w_valid[0]     = in_valid;
    assign w_data[0]      = in_data;
    assign w_ready[DEPTH] = out_ready;

    genvar k;
    generate
        for (k = 0; k < DEPTH; k++) begin : g_stage
            pipe_skid_stage #(
                .WIDTH      (WIDTH),
                .DEFAULT_VAL(DEFAULT_VAL)
            ) u_stage (
                .clk    (clk),
                .rst    (rst),
                .stall  (stall),
                .bubble (bubble),
                .i_valid(w_valid[k]),
                .i_data (w_data[k]),
                .o_ready(w_ready[k]),
                .o_valid(w_valid[k+1]),
                .o_data (w_data[k+1]),
                .i_ready(w_ready[k+1])
            );
        end
    endgenerate

    // Control inputs gate both handshakes so no transfer can be seen during freeze/flush/reset
    assign w_block   = rst | bubble | stall;
    assign in_ready  = w_ready[0] & ~w_block;
    assign out_valid = w_valid[DEPTH] & ~w_block;
    assign out_data  = rst ? DEFAULT_VAL : w_data[DEPTH];

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= 32'd0;
            r_flush_count  <= 32'd0;
        end else begin
            if (stall || (out_valid && !out_ready)) begin
                r_stall_cycles <= sat_inc(r_stall_cycles);
            end
            if (bubble) begin
                r_flush_count <= sat_inc(r_flush_count);
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_pipe_elastic_reg.sv
// tb/tb_pipe_elastic_reg.sv - directed vector bench for pipe_elastic_reg (DEPTH=2 and DEPTH=3 instances)
module tb_pipe_elastic_reg;

    logic        clk = 1'b0;
    logic        rst, stall, bubble, in_valid, out_ready;
    logic [31:0] in_data;
    logic        in_ready2, out_valid2, in_ready3, out_valid3;
    logic [31:0] out_data2, out_data3;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles2, flush_count2, stall_cycles3, flush_count3;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_elastic_reg #(.WIDTH(32), .DEPTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .stall(stall), .bubble(bubble),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2),
        .out_valid(out_valid2), .out_data(out_data2), .out_ready(out_ready)
`ifdef PIPE_PERF_CNT_EN
        , .stall_cycles(stall_cycles2), .flush_count(flush_count2)
`endif
    );

    pipe_elastic_reg #(.WIDTH(32), .DEPTH(3)) u_dut3 (
        .clk(clk), .rst(rst), .stall(stall), .bubble(bubble),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready3),
        .out_valid(out_valid3), .out_data(out_data3), .out_ready(out_ready)
`ifdef PIPE_PERF_CNT_EN
        , .stall_cycles(stall_cycles3), .flush_count(flush_count3)
`endif
    );

    typedef struct {
        logic        rst, stall, bubble, in_valid;
        logic [31:0] in_data;
        logic        out_ready;
        logic        exp_in_ready, exp_out_valid;
        logic [31:0] exp_out_data;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic s, input logic b, input logic iv,
                       input logic [31:0] d, input logic ordy,
                       input logic e_ir, input logic e_ov, input logic [31:0] e_od);
        vec_t v;
        v.rst = r; v.stall = s; v.bubble = b; v.in_valid = iv; v.in_data = d;
        v.out_ready = ordy; v.exp_in_ready = e_ir; v.exp_out_valid = e_ov; v.exp_out_data = e_od;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic b, input logic iv,
                         input logic [31:0] d, input logic ordy);
        rst = r; stall = s; bubble = b; in_valid = iv; in_data = d; out_ready = ordy;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0);

        // rst stall bub iv data ordy | in_ready out_valid out_data  (DEPTH=2)
        add(1, 0, 0, 0, 0,  0, 0, 0, 0);
        add(1, 0, 0, 0, 0,  0, 0, 0, 0);
        add(0, 0, 0, 1, 1,  0, 1, 0, 0);
        add(0, 0, 0, 1, 2,  0, 1, 0, 0);
        add(0, 0, 0, 1, 3,  0, 1, 1, 1);
        add(0, 0, 0, 1, 4,  0, 1, 1, 1);
        add(0, 0, 0, 1, 5,  0, 0, 1, 1);
        add(0, 0, 0, 1, 5,  0, 0, 1, 1);
        add(0, 0, 0, 1, 5,  1, 0, 1, 1);
        add(0, 0, 0, 1, 5,  1, 0, 1, 2);
        add(0, 0, 0, 1, 5,  1, 1, 1, 3);
        add(0, 0, 0, 0, 0,  1, 1, 1, 4);
        add(0, 0, 0, 0, 0,  1, 1, 1, 5);
        add(0, 0, 0, 0, 0,  1, 1, 0, 0);
        add(0, 0, 0, 1, 10, 1, 1, 0, 0);
        add(0, 0, 0, 1, 11, 1, 1, 0, 0);
        add(0, 1, 0, 1, 12, 1, 0, 0, 10);
        add(0, 1, 0, 1, 12, 1, 0, 0, 10);
        add(0, 0, 0, 1, 12, 1, 1, 1, 10);
        add(0, 0, 0, 0, 0,  1, 1, 1, 11);
        add(0, 0, 0, 0, 0,  1, 1, 1, 12);
        add(0, 0, 0, 0, 0,  1, 1, 0, 0);
        add(0, 0, 0, 1, 32'h21, 0, 1, 0, 0);
        add(0, 0, 0, 1, 32'h22, 0, 1, 0, 0);
        add(0, 0, 0, 1, 32'h23, 0, 1, 1, 32'h21);
        add(0, 1, 1, 1, 32'h24, 1, 0, 0, 32'h21);
        add(0, 0, 0, 0, 0,  1, 1, 0, 0);
        add(0, 0, 0, 1, 32'h55, 1, 1, 0, 0);
        add(0, 0, 0, 0, 0,  1, 1, 0, 0);
        add(0, 0, 0, 0, 0,  1, 1, 1, 32'h55);
        add(0, 0, 0, 0, 0,  1, 1, 0, 0);
        add(0, 0, 0, 1, 32'h66, 1, 1, 0, 0);
        add(1, 0, 1, 0, 0,  1, 0, 0, 0);
        add(0, 0, 0, 0, 0,  1, 1, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].stall, vecs[i].bubble, vecs[i].in_valid,
                  vecs[i].in_data, vecs[i].out_ready);
            #1;
            check($sformatf("row%0d in_ready", i),  {31'd0, in_ready2},  {31'd0, vecs[i].exp_in_ready});
            check($sformatf("row%0d out_valid", i), {31'd0, out_valid2}, {31'd0, vecs[i].exp_out_valid});
            check($sformatf("row%0d out_data", i),  out_data2, vecs[i].exp_out_data);
        end

        // DEPTH=3 latency: one push, visible exactly after the third edge, then gone
        @(negedge clk);
        drive(0, 0, 0, 1, 32'hDEAD_BEEF, 1);
        #1;
        check("lat in_ready", {31'd0, in_ready3}, 32'd1);
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 1);
            #1;
            check($sformatf("lat%0d out_valid", n), {31'd0, out_valid3}, (n == 3) ? 32'd1 : 32'd0);
            check($sformatf("lat%0d out_data", n), out_data3, (n == 3) ? 32'hDEAD_BEEF : 32'd0);
        end

`ifdef PIPE_PERF_CNT_EN
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            drive(0, 1, 0, 0, 0, 1);
        end
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            drive(0, 0, 1, 0, 0, 1);
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 1);
        end
        @(negedge clk);
        #1;
        check("dut2 stall_cycles", stall_cycles2, 32'd5);
        check("dut2 flush_count",  flush_count2,  32'd2);
        check("dut3 stall_cycles", stall_cycles3, 32'd5);
        check("dut3 flush_count",  flush_count3,  32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_elastic_reg.md
Name: pipe_elastic_reg

Overview:
- Parametrised successor to the fixed-width stall/bubble pipeline registers between pipeline stages.
- Carries a WIDTH-bit payload through DEPTH elastic stages with a valid/ready handshake on both sides.
- Keeps the global stall (freeze) and bubble (flush) controls.
- Each stage has a 2-entry skid buffer, so in_ready is registered, not a combinational path from out_ready, and throughput is one item per cycle.
- Usable as a decoupling register between the core pipeline and the accelerator path.

Parameters:
- WIDTH, 32, payload width in bits (>=1).
- DEPTH, 1, number of elastic stages in series (>=1).
- DEFAULT_VAL, {WIDTH{1'b0}}, payload value of an empty, flushed or reset stage.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  freeze all stages.
- bubble  input  1  flush all stages.
- in_valid  input  1  upstream has payload.
- in_data  input  WIDTH  upstream payload.
- in_ready  output  1  block accepts in_data this cycle.
- out_valid  output  1  out_data is valid.
- out_data  output  WIDTH  head payload.
- out_ready  input  1  downstream accepts this cycle.

Behaviour:
- Clocking and reset:
  - Single clock (clk); reset is synchronous and active-high (rst).
  - After an rst edge, every stage is EMPTY and all payload registers equal DEFAULT_VAL.
  - While rst=1: in_ready=0, out_valid=0, out_data=DEFAULT_VAL.
  - rst asserted mid-transfer discards all contents. No partial state survives.
- Transfers:
  - Input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
  - Stages are chained with the same rule: stage k output feeds stage k+1 input.
- Stage FSM, per stage (2-bit, states: EMPTY, HALF, FULL):
  - EMPTY: accept -> HALF, data goes to the main register.
  - HALF:
    - accept without drain -> FULL (data goes to the skid register);
    - drain without accept -> EMPTY;
    - accept and drain together -> HALF (main register loads the new data).
  - FULL:
    - drain -> HALF (skid moves to main, skid becomes DEFAULT_VAL);
    - no accept is possible in FULL.
- Stage signals:
  - Stage ready = (state != FULL), taken from a register.
  - Stage valid = (state != EMPTY).
- Latency and throughput:
  - An accepted item appears on out_valid exactly DEPTH cycles later if the pipe is empty and out_ready=1.
  - Sustained throughput is 1 item/cycle.
  - Capacity is 2*DEPTH items. Order is strict FIFO.
- stall=1:
  - No stage state or payload changes.
  - in_ready=0 and out_valid=0, both gated combinationally, so no transfer on either side.
  - out_data holds its value.
- bubble=1:
  - On the next edge all stages become EMPTY and all payloads become DEFAULT_VAL.
  - In the same cycle in_ready=0 and out_valid=0, so nothing is accepted or emitted.
- Priority: rst > bubble > stall > handshake.
- out_data = main register of the last stage. It equals DEFAULT_VAL whenever that stage is EMPTY.
- Full boundary: with all stages FULL and out_ready=0, in_ready=0 from the next cycle. Input held on in_data is not lost and waits.
- Empty boundary: with all stages EMPTY, out_valid=0 regardless of out_ready.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- When defined, two output ports are added:
  - stall_cycles [31:0]: counts cycles with stall=1, or with out_valid=1 and out_ready=0.
  - flush_count [31:0]: counts cycles with bubble=1 and rst=0.
- Both counters reset to 0 on rst and saturate at 32'hFFFF_FFFF. They are not cleared by bubble.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared defines include: stage state localparams ST_EMPTY=2'd0, ST_HALF=2'd1, ST_FULL=2'd2.
- Sub-module pipe_skid_stage (WIDTH, DEFAULT_VAL): one FSM, main and skid registers, stall/bubble inputs.
- Top level instantiates DEPTH copies using a generate loop and chains their valid/ready signals.

Test Plan:
- Latency: DEPTH=3, WIDTH=32, out_ready=1, one push of 32'hDEAD_BEEF -> out_valid rises exactly 3 cycles later with out_data=32'hDEAD_BEEF, then falls.
- Backpressure and fill: DEPTH=2, out_ready=0, push 1,2,3,4,5 back-to-back -> in_ready drops after 4 items accepted, 5 is held. Release out_ready -> outputs are 1,2,3,4,5 in order, no loss and no duplicates.
- Stall: streaming 10..19 with stall=1 for cycles 4-6 -> no transfers and no state change during the stall. The sequence resumes intact with the same order.
- Bubble: pipe holding 3 items, pulse bubble for 1 cycle -> next cycle out_valid=0 and out_data=DEFAULT_VAL. A subsequent push of 32'h55 exits after DEPTH cycles.
- Priority: bubble and stall asserted together -> flush occurs. rst and bubble asserted together -> reset state.
- Counters (PIPE_PERF_CNT_EN defined): 5 stalled cycles plus 2 bubble pulses -> stall_cycles=5, flush_count=2. Preload stall_cycles to 32'hFFFF_FFFF -> further stalls leave it unchanged.
